approx_add_pipe: RTL
====================

# approx_add_pipe

- Parametrised, pipelined successor to the combinational ripple-carry approximate adder.
- Splits a SIZE-bit signed add/subtract into STAGES carry-registered chunks, with a valid/ready handshake on both sides.
- The number of approximate low-order bits is set per transaction at run time.
- Sits between DCT butterfly stages wherever a wide approximate add would otherwise limit clock frequency.

## Interface
- SIZE, 16: operand width in bits; must be divisible by STAGES.
- STAGES, 2: pipeline stages; chunk width is CHUNK = SIZE/STAGES.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a, b  in  SIZE  signed operands.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: compute a-b; 0: compute a+b+cin.
- approx_bits  in  $clog2(SIZE+1)  number of low bits using approximate cells (0..SIZE); values above SIZE are clamped to SIZE.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  SIZE+1  sign-extended signed result.
- cout  out  1  unsigned carry out of bit SIZE-1.

## Operation
- Accept rule: a beat is accepted when in_valid && in_ready. a, b, cin, sub and approx_bits are captured together.
- Subtraction: b is inverted and the effective cin is forced to 1.
- Approximate mask: mask[i] = (i < approx_bits).
- Exact cell: full adder.
- Approximate cell: sum_i = a_i ^ b_i; cout_i = a_i & b_i; the incoming carry is ignored.
  - The carry out of an approximate cell feeds the next cell normally.
- Bit SIZE: an exact cell on the sign-extended operand MSBs, using the inverted b MSB when sub=1. It is never approximate.
- Stage k (0..STAGES-1):
  - Adds chunk k using the carry registered by stage k-1. Stage 0 uses the effective cin.
  - Unconsumed operand chunks, the mask and sub travel in skew registers alongside each stage.
  - Computed low chunks travel forward in result registers alongside each stage.
- The final stage also computes bit SIZE and cout, then applies saturation if it is compiled in.
- Flow control:
  - One global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - Per-stage valid bits shift on adv; all stages hold when adv=0.
- No reordering and no drops. Full throughput is one result per cycle while out_ready=1.

## Timing
- Latency: the beat accepted in cycle t has out_valid=1 in cycle t+STAGES, provided there is no backpressure.
- Reset: all valid bits, sum, cout and carry registers go to 0 asynchronously. in_ready=1 once reset is released.
- Reset mid-operation: all in-flight beats are discarded and no partial result is ever presented.
- Output stability: sum, cout and out_valid are registered and held stable while out_valid && !out_ready.
- Simultaneous events: when out_ready rises in the same cycle a new beat arrives, the head is retired and the new beat enters in that same cycle.
- in_valid=0 bubbles propagate as invalid stages and do not stall upstream.

## Configuration
- APPROX_ADD_SAT_EN defined: the result is clamped to the SIZE-bit signed range [-2^(SIZE-1), 2^(SIZE-1)-1] and sign-extended into sum. cout is unaffected.
- APPROX_ADD_SAT_EN undefined: sum is the full SIZE+1-bit result.

## Structure
- Package approx_add_pkg holds:
  - the stage payload struct (remaining a/b chunks, mask, sub, partial sum, carry, valid);
  - the helper function computing CHUNK and the mask width.
- Sub-module approx_add_chunk: combinational CHUNK-bit adder with a per-bit approximate mask, carry in and carry out. It is instantiated once per stage.

## Test plan
Unless a scenario states otherwise: SIZE=8, STAGES=2, out_ready=1, APPROX_ADD_SAT_EN undefined.
- Exact add: a=100, b=27, cin=0, sub=0, approx_bits=0 -> after 2 cycles sum=9'sd127, cout=0.
- Sign extension: a=-128, b=-1, approx_bits=0 -> sum=9'h17F (-129), cout=1.
- Approximate add: a=8'h0F, b=8'h01, approx_bits=4 -> sum=9'h00E (exact result would be 16), cout=0.
- Subtract: a=5, b=7, sub=1, cin=1 -> sum=9'h1FE (-2), cout=0. Repeat with cin=0 -> identical result.
- Saturation: a=100, b=100 -> sum=9'h0C8 with APPROX_ADD_SAT_EN undefined; sum=9'sd127 with it defined.
- Backpressure and reset:
  - Send 4 back-to-back beats while holding out_ready=0 for 3 cycles -> in_ready drops, results arrive in order with none lost.
  - Assert rst_n=0 while beats are in flight -> out_valid=0 and sum=0 immediately, and no stale result appears after release.

Source files
------------

// File: rtl/approx_add_pkg.sv
// Shared types and sizing helpers for the pipelined approximate adder.
// Optional saturation is selected in approx_add_pipe with APPROX_ADD_SAT_EN.
package approx_add_pkg;

  localparam int unsigned MAX_SIZE = 64;

  // Per-stage payload; only the low SIZE bits of the wide fields are meaningful.
  typedef struct packed {
    logic [MAX_SIZE-1:0] a_rem;
    logic [MAX_SIZE-1:0] b_rem;
    logic [MAX_SIZE-1:0] mask;
    logic                sub;
    logic [MAX_SIZE-1:0] psum;
    logic                carry;
    logic                valid;
  } stage_t;

  function automatic int unsigned chunk_width(input int unsigned size,
                                              input int unsigned stages);
    return size / stages;
  endfunction

  function automatic int unsigned mask_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/approx_add_chunk.sv
// Combinational W-bit ripple adder; masked bits use the approximate cell
// (sum = a^b, carry = a&b, incoming carry ignored).
module approx_add_chunk
  import approx_add_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_mask,
  input  logic         i_cin,
  output logic [W-1:0] o_sum_c,
  output logic         o_cout_c
);

  logic [W:0] w_c;

  always_comb begin
    w_c     = '0;
    o_sum_c = '0;
    w_c[0]  = i_cin;
    for (int i = 0; i < W; i++) begin
      if (i_mask[i]) begin
        o_sum_c[i] = i_a[i] ^ i_b[i];
        w_c[i+1]   = i_a[i] & i_b[i];
      end else begin
        o_sum_c[i] = i_a[i] ^ i_b[i] ^ w_c[i];
        w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
    end
  end

  assign o_cout_c = w_c[W];

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined signed approximate add/subtract, one CHUNK per stage, valid/ready on both sides.
// Define APPROX_ADD_SAT_EN to clamp the result to the SIZE-bit signed range.
module approx_add_pipe
  import approx_add_pkg::*;
#(
  parameter int unsigned SIZE   = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic [SIZE-1:0]              i_a,
  input  logic [SIZE-1:0]              i_b,
  input  logic                         i_cin,
  input  logic                         i_sub,
  input  logic [mask_width(SIZE)-1:0]  i_approx_bits,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [SIZE:0]                o_sum,
  output logic                         o_cout
);

  localparam int unsigned CHUNK = chunk_width(SIZE, STAGES);
  localparam int unsigned AW    = mask_width(SIZE);
  localparam int unsigned LAST  = STAGES - 1;

  stage_t r_stage [STAGES];
  stage_t w_cur   [STAGES];
  stage_t w_nxt   [STAGES];

  logic [STAGES-1:0][CHUNK-1:0] w_ch_a;
  logic [STAGES-1:0][CHUNK-1:0] w_ch_b;
  logic [STAGES-1:0][CHUNK-1:0] w_ch_mask;
  logic [STAGES-1:0][CHUNK-1:0] w_ch_sum;
  logic [STAGES-1:0]            w_ch_cin;
  logic [STAGES-1:0]            w_ch_cout;

  logic [SIZE:0] w_full;
  logic [SIZE:0] w_sum_nxt;
  logic          w_msb;
  logic          w_adv;
  logic          w_unused;
  logic [SIZE:0] r_sum;
  logic          r_cout;

  assign w_adv       = !o_out_valid || i_out_ready;
  assign o_in_ready  = w_adv;
  assign o_out_valid = r_stage[LAST].valid;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;

  // Stage inputs: stage 0 from the ports, later stages from the previous stage register.
  always_comb begin
    w_cur[0]                  = '0;
    w_cur[0].a_rem[SIZE-1:0]  = i_a;
    w_cur[0].b_rem[SIZE-1:0]  = i_b;
    // Values above SIZE naturally yield an all-ones mask.
    for (int i = 0; i < SIZE; i++) begin
      w_cur[0].mask[i] = (AW'(i) < i_approx_bits);
    end
    w_cur[0].sub   = i_sub;
    w_cur[0].carry = i_sub | i_cin;
    w_cur[0].valid = i_in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_cur[k] = r_stage[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_ch_a[k]    = w_cur[k].a_rem[CHUNK-1:0];
      w_ch_b[k]    = w_cur[k].sub ? ~w_cur[k].b_rem[CHUNK-1:0] : w_cur[k].b_rem[CHUNK-1:0];
      w_ch_mask[k] = w_cur[k].mask[CHUNK-1:0];
      w_ch_cin[k]  = w_cur[k].carry;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    approx_add_chunk #(.W(CHUNK)) u_chunk (
      .i_a      (w_ch_a[k]),
      .i_b      (w_ch_b[k]),
      .i_mask   (w_ch_mask[k]),
      .i_cin    (w_ch_cin[k]),
      .o_sum_c  (w_ch_sum[k]),
      .o_cout_c (w_ch_cout[k])
    );
  end

  // Stage outputs: consume one chunk, append its sum, forward the carry.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt[k]                        = w_cur[k];
      w_nxt[k].a_rem                  = w_cur[k].a_rem >> CHUNK;
      w_nxt[k].b_rem                  = w_cur[k].b_rem >> CHUNK;
      w_nxt[k].mask                   = w_cur[k].mask >> CHUNK;
      w_nxt[k].psum[k*CHUNK +: CHUNK] = w_ch_sum[k];
      w_nxt[k].carry                  = w_ch_cout[k];
    end
    // Bit SIZE is an exact cell on the sign-extended MSBs.
    w_msb  = w_cur[LAST].a_rem[CHUNK-1] ^ w_ch_b[LAST][CHUNK-1] ^ w_ch_cout[LAST];
    w_full = {w_msb, w_nxt[LAST].psum[SIZE-1:0]};
`ifdef APPROX_ADD_SAT_EN
    if (w_msb != w_full[SIZE-1]) begin
      w_sum_nxt = w_msb ? {2'b11, {(SIZE-1){1'b0}}} : {2'b00, {(SIZE-1){1'b1}}};
    end else begin
      w_sum_nxt = w_full;
    end
`else
    w_sum_nxt = w_full;
`endif
  end

  // Pipeline registers; everything holds when the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= w_nxt[k];
      end
      if (w_nxt[LAST].valid) begin
        r_sum  <= w_sum_nxt;
        r_cout <= w_ch_cout[LAST];
      end
    end
  end

  // Upper payload bits and the final stage's skew fields are never consumed.
  always_comb begin
    w_unused = ^r_stage[LAST];
    for (int k = 0; k < STAGES; k++) begin
      w_unused = w_unused ^ (^w_cur[k]) ^ (^w_nxt[k]);
    end
  end

endmodule
